// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: operation encoding and the status-flag bundle.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SHL = 3'b110,
    ALU_SHR = 3'b111
  } alu_op_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic neg;
    logic ovf;
  } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: one operation on a/b producing result and status flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  alu_op_t          op_i,
  output logic [WIDTH-1:0] result_o,
  output alu_flags_t       flags_o
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             ovf;

  assign sum   = {1'b0, a_i} + {1'b0, b_i};
  assign diff  = {1'b0, a_i} - {1'b0, b_i};
  assign shamt = b_i[SHW-1:0];

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    unique case (op_i)
      ALU_ADD: begin
        res   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      ALU_SUB: begin
        // The extra top bit of the widened difference is the unsigned borrow.
        res   = diff[WIDTH-1:0];
        carry = diff[WIDTH];
        ovf   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
      end
      ALU_AND: res = a_i & b_i;
      ALU_OR:  res = a_i | b_i;
      ALU_XOR: res = a_i ^ b_i;
      ALU_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SHL: res = a_i << shamt;
      ALU_SHR: res = a_i >> shamt;
      default: res = '0;
    endcase
  end

  assign result_o      = res;
  assign flags_o.zero  = (res == '0);
  assign flags_o.carry = carry;
  assign flags_o.neg   = res[WIDTH-1];
  assign flags_o.ovf   = ovf;

endmodule

// File: rtl/pipelined_alu.sv
// Two-stage valid/ready ALU pipeline with accumulator operand and sticky overflow.
module pipelined_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  alu_op_t          op_i,
  input  logic             acc_i,
  input  logic             acc_clr_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             carry_o,
  output logic             neg_o,
  output logic             ovf_o,
  output logic             ovf_sticky_o
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_result_q, s1_result_d;
  alu_flags_t       s1_flags_q, s1_flags_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_result_q, s2_result_d;
  alu_flags_t       s2_flags_q, s2_flags_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             sticky_q, sticky_d;

  logic             s1_adv, s2_adv, in_fire;
  logic [WIDTH-1:0] op_a, alu_result;
  alu_flags_t       alu_flags;

  assign s2_adv     = !s2_valid_q || out_ready_i;
  assign s1_adv     = !s1_valid_q || s2_adv;
  assign in_ready_o = s1_adv;
  assign in_fire    = in_valid_i && s1_adv;
  assign op_a       = acc_i ? acc_q : a_i;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a_i      (op_a),
    .b_i      (b_i),
    .op_i     (op_i),
    .result_o (alu_result),
    .flags_o  (alu_flags)
  );

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_result_d = s1_result_q;
    s1_flags_d  = s1_flags_q;
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_flags_d  = s2_flags_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;

    if (s1_adv) s1_valid_d = in_fire;
    if (in_fire) begin
      s1_result_d = alu_result;
      s1_flags_d  = alu_flags;
      acc_d       = alu_result;
      sticky_d    = sticky_q | alu_flags.ovf;
    end
    // Clear takes priority over the update from an op accepted in the same cycle.
    if (acc_clr_i) begin
      acc_d    = '0;
      sticky_d = 1'b0;
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_result_d = s1_result_q;
        s2_flags_d  = s1_flags_q;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s1_valid_q  <= 1'b0;
      s1_result_q <= '0;
      s1_flags_q  <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_flags_q  <= '0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_result_q <= s1_result_d;
      s1_flags_q  <= s1_flags_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_flags_q  <= s2_flags_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
    end
  end

  assign out_valid_o  = s2_valid_q;
  assign result_o     = s2_result_q;
  assign zero_o       = s2_flags_q.zero;
  assign carry_o      = s2_flags_q.carry;
  assign neg_o        = s2_flags_q.neg;
  assign ovf_o        = s2_flags_q.ovf;
  assign ovf_sticky_o = sticky_q;

endmodule

// File: tb/tb_pipelined_alu.sv
// Self-checking bench for pipelined_alu: scoreboard against an arithmetic reference model.
module tb_pipelined_alu;
  import alu_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       in_valid_i, in_ready_o;
  logic [7:0] a_i, b_i;
  alu_op_t    op_i;
  logic       acc_i, acc_clr_i;
  logic       out_valid_o, out_ready_i;
  logic [7:0] result_o;
  logic       zero_o, carry_o, neg_o, ovf_o, ovf_sticky_o;

  pipelined_alu #(.WIDTH(8)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .a_i          (a_i),
    .b_i          (b_i),
    .op_i         (op_i),
    .acc_i        (acc_i),
    .acc_clr_i    (acc_clr_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .result_o     (result_o),
    .zero_o       (zero_o),
    .carry_o      (carry_o),
    .neg_o        (neg_o),
    .ovf_o        (ovf_o),
    .ovf_sticky_o (ovf_sticky_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] res;
    logic       z, c, n, v;
    int         acc_edge;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] out_log[$];
  int         checks = 0;
  int         errors = 0;
  int         edge_cnt = 0;
  int         n_out = 0;
  bit         last_in_fire;
  logic [7:0] m_acc = 8'h00;
  logic       m_sticky = 1'b0;

  // Reference model: signed/unsigned integer arithmetic, then reduce to 8 bits.
  function automatic void ref_alu(input int op, input int a, input int b, output exp_t e);
    int sa, sbv, r;
    sa  = (a >= 128) ? a - 256 : a;
    sbv = (b >= 128) ? b - 256 : b;
    e.c = 1'b0;
    e.v = 1'b0;
    case (op)
      0: begin r = a + b; e.c = (r > 255); e.v = (sa + sbv > 127) || (sa + sbv < -128); end
      1: begin r = a - b; e.c = (a < b);   e.v = (sa - sbv > 127) || (sa - sbv < -128); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (sa < sbv) ? 1 : 0;
      6: r = a << (b % 8);
      default: r = a >> (b % 8);
    endcase
    r     = r & 255;
    e.res = 8'(r);
    e.z   = (r == 0);
    e.n   = (r >= 128);
    e.acc_edge = 0;
  endfunction

  // One clock: evaluate handshakes before the edge, update the model, check sticky after it.
  task automatic cycle();
    exp_t e;
    logic exp_ready, exp_valid;
    #1;
    exp_ready = (sb_q.size() < 2) || out_ready_i;
    exp_valid = (sb_q.size() > 0) && (edge_cnt >= sb_q[0].acc_edge + 1);
    checks++;
    if (in_ready_o !== exp_ready) begin
      errors++;
      $display("FAIL in_ready edge=%0d got=%b exp=%b", edge_cnt, in_ready_o, exp_ready);
    end
    checks++;
    if (out_valid_o !== exp_valid) begin
      errors++;
      $display("FAIL out_valid edge=%0d got=%b exp=%b", edge_cnt, out_valid_o, exp_valid);
    end
    if (out_valid_o === 1'b1 && out_ready_i) begin
      n_out++;
      out_log.push_back(result_o);
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output edge=%0d got=%h exp=none", edge_cnt, result_o);
      end else begin
        e = sb_q.pop_front();
        if ({result_o, zero_o, carry_o, neg_o, ovf_o} !== {e.res, e.z, e.c, e.n, e.v}) begin
          errors++;
          $display("FAIL result edge=%0d got=%h zcnv=%b%b%b%b exp=%h zcnv=%b%b%b%b", edge_cnt,
                   result_o, zero_o, carry_o, neg_o, ovf_o, e.res, e.z, e.c, e.n, e.v);
        end
      end
    end
    last_in_fire = in_valid_i && in_ready_o;
    if (last_in_fire) begin
      ref_alu(int'(op_i), acc_i ? int'(m_acc) : int'(a_i), int'(b_i), e);
      e.acc_edge = edge_cnt + 1;
      sb_q.push_back(e);
      m_acc    = e.res;
      m_sticky = m_sticky | e.v;
    end
    if (acc_clr_i) begin
      m_acc    = 8'h00;
      m_sticky = 1'b0;
    end
    @(posedge clk_i);
    edge_cnt++;
    @(negedge clk_i);
    checks++;
    if (ovf_sticky_o !== m_sticky) begin
      errors++;
      $display("FAIL ovf_sticky edge=%0d got=%b exp=%b", edge_cnt, ovf_sticky_o, m_sticky);
    end
  endtask

  task automatic drive(input bit v, input alu_op_t op, input logic [7:0] a, input logic [7:0] b,
                       input bit acc, input bit clr, input bit rdy);
    in_valid_i  = v;
    op_i        = op;
    a_i         = a;
    b_i         = b;
    acc_i       = acc;
    acc_clr_i   = clr;
    out_ready_i = rdy;
  endtask

  task automatic drain();
    drive(1'b0, ALU_ADD, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) cycle();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got=%0d pending exp=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    drive(1'b0, ALU_ADD, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    #3;
    checks++;
    if ({out_valid_o, result_o, zero_o, carry_o, neg_o, ovf_o, ovf_sticky_o} !== 14'h0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=0",
               {out_valid_o, result_o, zero_o, carry_o, neg_o, ovf_o, ovf_sticky_o});
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    checks++;
    if (in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready_o);
    end
  endtask

  task automatic test_latency();
    drive(1'b1, ALU_ADD, 8'h05, 8'h03, 1'b0, 1'b0, 1'b1);
    cycle();
    drive(1'b0, ALU_ADD, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL latency_early got=%b exp=0", out_valid_o);
    end
    cycle();
    #1;
    checks++;
    if ({out_valid_o, result_o, zero_o, carry_o} !== {1'b1, 8'h08, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL latency_add got=v%b r=%h z%b c%b exp=v1 r=08 z0 c0",
               out_valid_o, result_o, zero_o, carry_o);
    end
    drain();
  endtask

  task automatic test_flags_shifts();
    alu_op_t    ops [6] = '{ALU_ADD, ALU_ADD, ALU_SUB, ALU_SLT, ALU_SHL, ALU_SHR};
    logic [7:0] as  [6] = '{8'hFF, 8'h7F, 8'h02, 8'h80, 8'h81, 8'h80};
    logic [7:0] bs  [6] = '{8'h01, 8'h01, 8'h03, 8'h01, 8'h09, 8'h07};
    logic [7:0] exp [6] = '{8'h00, 8'h80, 8'hFF, 8'h01, 8'h02, 8'h01};
    out_log.delete();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, ops[i], as[i], bs[i], 1'b0, 1'b0, 1'b1);
      cycle();
    end
    drain();
    checks++;
    if (out_log.size() != 6) begin
      errors++;
      $display("FAIL flags_count got=%0d exp=6", out_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (out_log[i] !== exp[i]) begin
          errors++;
          $display("FAIL flags_result[%0d] got=%h exp=%h", i, out_log[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int   idx = 0;
    int   out0 = n_out;
    exp_t first;
    ref_alu(0, 1, 0, first);
    for (int cyc = 0; cyc < 30 && (idx < 5 || sb_q.size() > 0); cyc++) begin
      drive(idx < 5, ALU_ADD, 8'(10 * idx + 1), 8'(idx), 1'b0, 1'b0, cyc >= 4);
      cycle();
      if (last_in_fire) idx++;
      if (cyc >= 1 && cyc <= 3) begin
        checks++;
        if (result_o !== first.res || out_valid_o !== 1'b1) begin
          errors++;
          $display("FAIL stall_hold cyc=%0d got=v%b %h exp=v1 %h", cyc, out_valid_o, result_o, first.res);
        end
      end
      if (cyc == 3) begin
        checks++;
        if (idx != 2) begin
          errors++;
          $display("FAIL stall_accepted got=%0d exp=2", idx);
        end
      end
    end
    checks++;
    if (idx != 5 || n_out - out0 != 5) begin
      errors++;
      $display("FAIL stream_count got=in%0d out%0d exp=in5 out5", idx, n_out - out0);
    end
    drain();
  endtask

  task automatic test_accumulator();
    logic [7:0] exp [5] = '{8'h03, 8'h07, 8'h0C, 8'h0D, 8'h01};
    logic [7:0] bs  [5] = '{8'h03, 8'h04, 8'h05, 8'h01, 8'h01};
    drive(1'b0, ALU_ADD, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    cycle();
    out_log.delete();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, ALU_ADD, 8'hAA, bs[i], 1'b1, i == 3, 1'b1);
      cycle();
    end
    drain();
    checks++;
    if (out_log.size() != 5) begin
      errors++;
      $display("FAIL acc_count got=%0d exp=5", out_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (out_log[i] !== exp[i]) begin
          errors++;
          $display("FAIL acc_result[%0d] got=%h exp=%h", i, out_log[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_sticky_reset();
    drive(1'b0, ALU_ADD, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    cycle();
    drive(1'b1, ALU_ADD, 8'h7F, 8'h7F, 1'b0, 1'b0, 1'b1);
    cycle();
    drive(1'b1, ALU_AND, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    cycle();
    drive(1'b1, ALU_OR, 8'h01, 8'h02, 1'b0, 1'b0, 1'b1);
    cycle();
    drive(1'b1, ALU_XOR, 8'h03, 8'h03, 1'b0, 1'b0, 1'b1);
    cycle();
    checks++;
    if (ovf_sticky_o !== 1'b1) begin
      errors++;
      $display("FAIL sticky_held got=%b exp=1", ovf_sticky_o);
    end
    drive(1'b1, ALU_SUB, 8'h80, 8'h01, 1'b0, 1'b0, 1'b1);
    cycle();
    #2;
    rst_i = 1'b0;
    #1;
    checks++;
    if ({out_valid_o, result_o, zero_o, carry_o, neg_o, ovf_o, ovf_sticky_o} !== 14'h0) begin
      errors++;
      $display("FAIL midstream_reset got=%b exp=0",
               {out_valid_o, result_o, zero_o, carry_o, neg_o, ovf_o, ovf_sticky_o});
    end
    sb_q.delete();
    m_acc    = 8'h00;
    m_sticky = 1'b0;
    drive(1'b0, ALU_ADD, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    @(negedge clk_i);
    rst_i = 1'b1;
    cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, alu_op_t'($urandom_range(0, 7)), 8'($urandom),
            8'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
            $urandom_range(0, 9) < 7);
      cycle();
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_flags_shifts();
    test_back_to_back();
    test_accumulator();
    test_sticky_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
